ps2_keyboard_fifo: RTL and testbench

//  PS/2 keyboard receiver: syncs and filters the PS/2 lines, decodes 11-bit frames with odd-parity
//  and stop checks, and folds the E0/F0 prefixes into key events.

---
 rtl/ps2_keyboard_fifo_if.sv | 10 +
 rtl/ps2_keyboard_fifo.sv | 170 +++++++++++++++++
 tb/tb_ps2_keyboard_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_fifo_if.sv
// PicoBlaze port-mapped read bus between the CPU (master) and the keyboard block (slave).
interface ps2_keyboard_fifo_if;
    logic [7:0] Port_ID;
    logic       Read_Strobe;
    logic [7:0] Keyboard_Output;
    logic       Interrupt;

    modport master (output Port_ID, Read_Strobe, input Keyboard_Output, Interrupt);
    modport slave  (input Port_ID, Read_Strobe, output Keyboard_Output, Interrupt);
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: line conditioning, 11-bit frame decode, E0/F0 prefix folding,
// and an event FIFO read through four consecutive PicoBlaze ports.
module ps2_keyboard_fifo #(
    parameter logic [7:0] BASE_PORT    = 8'h05,
    parameter int         FIFO_DEPTH   = 8,
    parameter int         FILTER_LEN   = 8,
    parameter int         TIMEOUT_CYC  = 200000,
    parameter bit         REPORT_BREAK = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PS2_Clock,
    input  logic PS2_Data,
    ps2_keyboard_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] P1 = BASE_PORT + 8'd1;
    localparam logic [7:0] P2 = BASE_PORT + 8'd2;
    localparam logic [7:0] P3 = BASE_PORT + 8'd3;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d;
    logic          rs_q, rs_d;
    logic [7:0]    out_q, out_d;
    logic          irq_q, irq_d;

    logic       fall, sd, emit, ferr_set, perr_set;
    logic       push, do_push, do_pop, rise, clr, empty, full;
    logic [9:0] head;

    // Clock filter: the synced clock must disagree with the filtered value for
    // FILTER_LEN consecutive cycles before the filtered value follows it.
    always_comb begin
        csync_d = {csync_q[0], PS2_Clock};
        dsync_d = {dsync_q[0], PS2_Data};
        filt_d  = filt_q;
        fcnt_d  = '0;
        if (csync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = csync_q[1];
            else                               fcnt_d = fcnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
        sd   = dsync_q[1];
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tcnt_d   = '0;
        emit     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        if (state_q != S_IDLE && !fall) tcnt_d = tcnt_q + 1'b1;
        case (state_q)
            S_IDLE:   if (fall && !sd) begin state_d = S_DATA; bcnt_d = '0; end
            S_DATA:   if (fall) begin
                          shift_d = {sd, shift_q[7:1]};
                          bcnt_d  = bcnt_q + 1'b1;
                          if (bcnt_q == 3'd7) state_d = S_PARITY;
                      end
            S_PARITY: if (fall) begin par_d = sd; state_d = S_STOP; end
            S_STOP:   if (fall) begin
                          state_d  = S_IDLE;
                          ferr_set = ~sd;
                          perr_set = ~^{shift_q, par_q};
                          emit     = sd & ^{shift_q, par_q};
                      end
            default:  state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !fall && tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d  = S_IDLE;
            ferr_set = 1'b1;
            tcnt_d   = '0;
        end
        byte_d     = emit ? shift_q : byte_q;
        byte_vld_d = emit;
    end

    // Prefix folding; a discarded break still consumes the pending prefix flags.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (byte_vld_q) begin
            if (byte_q == 8'hE0)      ext_d = 1'b1;
            else if (byte_q == 8'hF0) brk_d = 1'b1;
            else begin
                push  = REPORT_BREAK | ~brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        head    = mem_q[rd_q[AW-1:0]];
        rs_d    = bus.Read_Strobe;
        rise    = bus.Read_Strobe & ~rs_q;
        do_pop  = rise && (bus.Port_ID == P3) && !empty;
        clr     = rise && (bus.Port_ID == BASE_PORT);
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = {ext_q, brk_q, byte_q};
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        // Set terms are OR'd after the clear so a simultaneous error survives.
        ferr_d  = (ferr_q & ~clr) | ferr_set;
        perr_d  = (perr_q & ~clr) | perr_set;
        ovf_d   = (ovf_q & ~clr) | (push & ~do_push);
        out_d   = 8'h00;
        if (bus.Port_ID == BASE_PORT)               out_d = {3'b0, ferr_q, perr_q, ovf_q, full, ~empty};
        else if (bus.Port_ID == P1 && !empty)       out_d = head[7:0];
        else if (bus.Port_ID == P2 && !empty)       out_d = {head[9:8], 6'b0};
        else if (bus.Port_ID == P3 && !empty)       out_d = head[7:0];
        irq_d   = ~empty;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            csync_q <= 2'b11;  dsync_q <= 2'b11;
            filt_q  <= 1'b1;   fcnt_q  <= '0;
            state_q <= S_IDLE; bcnt_q  <= '0;
            shift_q <= '0;     par_q   <= 1'b0;
            tcnt_q  <= '0;     byte_q  <= '0;
            byte_vld_q <= 1'b0;
            ext_q   <= 1'b0;   brk_q   <= 1'b0;
            wr_q    <= '0;     rd_q    <= '0;
            ferr_q  <= 1'b0;   perr_q  <= 1'b0;   ovf_q <= 1'b0;
            rs_q    <= 1'b0;   out_q   <= '0;     irq_q <= 1'b0;
        end else begin
            csync_q <= csync_d; dsync_q <= dsync_d;
            filt_q  <= filt_d;  fcnt_q  <= fcnt_d;
            state_q <= state_d; bcnt_q  <= bcnt_d;
            shift_q <= shift_d; par_q   <= par_d;
            tcnt_q  <= tcnt_d;  byte_q  <= byte_d;
            byte_vld_q <= byte_vld_d;
            ext_q   <= ext_d;   brk_q   <= brk_d;
            wr_q    <= wr_d;    rd_q    <= rd_d;
            ferr_q  <= ferr_d;  perr_q  <= perr_d;  ovf_q <= ovf_d;
            rs_q    <= rs_d;    out_q   <= out_d;   irq_q <= irq_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge CLK) mem_q <= mem_d;

    assign bus.Keyboard_Output = out_q;
    assign bus.Interrupt       = irq_q;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Bench for ps2_keyboard_fifo: two instances (break reporting on / off) driven by
// a bit-level PS/2 frame generator, with per-instance event scoreboards.
`timescale 1ns/1ps
module tb_ps2_keyboard_fifo;
    localparam logic [7:0] B  = 8'h05;
    localparam logic [7:0] P1 = 8'h06;
    localparam logic [7:0] P2 = 8'h07;
    localparam logic [7:0] P3 = 8'h08;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] ps2c = 2'b11;
    logic [1:0] ps2d = 2'b11;
    int total = 0;
    int bad = 0;
    logic [9:0] sb0[$];
    logic [9:0] sb1[$];
    bit mext[2];
    bit mbrk[2];

    always #5 CLK = ~CLK;

    ps2_keyboard_fifo_if bus0();
    ps2_keyboard_fifo_if bus1();

    ps2_keyboard_fifo #(.BASE_PORT(B), .FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT_CYC(2000), .REPORT_BREAK(1'b1))
        u_rb (.CLK(CLK), .RESET(RESET), .PS2_Clock(ps2c[0]), .PS2_Data(ps2d[0]), .bus(bus0.slave));
    ps2_keyboard_fifo #(.BASE_PORT(B), .FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT_CYC(2000), .REPORT_BREAK(1'b0))
        u_nb (.CLK(CLK), .RESET(RESET), .PS2_Clock(ps2c[1]), .PS2_Data(ps2d[1]), .bus(bus1.slave));

    // One PS/2 frame; data changes mid-high so it is stable around each falling edge.
    task automatic send_frame(input int d, input logic [7:0] b, input bit bad_par = 1'b0,
                              input bit bad_stop = 1'b0, input int nbits = 11);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK); ps2d[d] = bits[i];
            repeat (10) @(negedge CLK); ps2c[d] = 1'b0;
            repeat (20) @(negedge CLK); ps2c[d] = 1'b1;
            repeat (10) @(negedge CLK);
        end
        ps2d[d] = 1'b1;
        repeat (30) @(negedge CLK);
        if (nbits == 11 && !bad_par && !bad_stop) begin
            if (b == 8'hE0) mext[d] = 1'b1;
            else if (b == 8'hF0) mbrk[d] = 1'b1;
            else begin
                if (d == 0) begin
                    if (sb0.size() < 8) sb0.push_back({mext[0], mbrk[0], b});
                end else if (!mbrk[1]) begin
                    if (sb1.size() < 8) sb1.push_back({mext[1], mbrk[1], b});
                end
                mext[d] = 1'b0;
                mbrk[d] = 1'b0;
            end
        end
    endtask

    task automatic rd(input int d, input logic [7:0] port, input bit strobe, input int hold,
                      output logic [7:0] data);
        @(negedge CLK);
        if (d == 0) begin bus0.Port_ID = port; bus0.Read_Strobe = strobe; end
        else        begin bus1.Port_ID = port; bus1.Read_Strobe = strobe; end
        @(negedge CLK);
        data = (d == 0) ? bus0.Keyboard_Output : bus1.Keyboard_Output;
        repeat (hold - 1) @(negedge CLK);
        if (d == 0) bus0.Read_Strobe = 1'b0; else bus1.Read_Strobe = 1'b0;
    endtask

    task automatic pop_entry(input int d, output logic [9:0] got);
        logic [7:0] f, c;
        rd(d, P2, 1'b1, 1, f);
        rd(d, P3, 1'b1, 1, c);
        got = {f[7:6], c};
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        sb0.delete(); sb1.delete();
        mext = '{default: 1'b0}; mbrk = '{default: 1'b0};
    endtask

    task automatic test_reset();
        logic [7:0] v;
        bus0.Port_ID = 8'h00; bus0.Read_Strobe = 1'b0;
        bus1.Port_ID = 8'h00; bus1.Read_Strobe = 1'b0;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (bus0.Keyboard_Output !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", bus0.Keyboard_Output); end
        total++; if (bus0.Interrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus0.Interrupt); end
        RESET = 1'b1;
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", v); end
    endtask

    task automatic test_single_key();
        logic [7:0] v; logic [9:0] got, exp;
        send_frame(0, 8'h1C);
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL t1_status got=%h want=01", v); end
        total++; if (bus0.Interrupt !== 1'b1) begin bad++; $display("FAIL t1_irq got=%b want=1", bus0.Interrupt); end
        rd(0, P1, 1'b1, 1, v);
        total++; if (v !== 8'h1C) begin bad++; $display("FAIL t1_head got=%h want=1c", v); end
        pop_entry(0, got);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if (got !== exp) begin bad++; $display("FAIL t1_pop got=%h want=%h", got, exp); end
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t1_status_after got=%h want=00", v); end
        total++; if (bus0.Interrupt !== 1'b0) begin bad++; $display("FAIL t1_irq_after got=%b want=0", bus0.Interrupt); end
    endtask

    task automatic test_prefix();
        logic [7:0] v; logic [9:0] got, exp;
        send_frame(0, 8'hE0); send_frame(0, 8'hF0); send_frame(0, 8'h75);
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL t2_status got=%h want=01", v); end
        pop_entry(0, got);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if (got !== exp) begin bad++; $display("FAIL t2_pop got=%h want=%h", got, exp); end
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t2_empty got=%h want=00", v); end
    endtask

    task automatic test_no_break();
        logic [7:0] v; logic [9:0] got, exp;
        send_frame(1, 8'h1C); send_frame(1, 8'hF0); send_frame(1, 8'h1C); send_frame(1, 8'h33);
        for (int i = 0; i < 2; i++) begin
            pop_entry(1, got);
            exp = sb1.size() ? sb1.pop_front() : 10'h3FF;
            total++; if (got !== exp) begin bad++; $display("FAIL t3_pop%0d got=%h want=%h", i, got, exp); end
        end
        rd(1, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t3_empty got=%h want=00", v); end
    endtask

    task automatic test_errors();
        logic [7:0] v;
        send_frame(0, 8'h1C, 1'b1, 1'b0);
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL t4_parity got=%h want=08", v); end
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t4_parity_clr got=%h want=00", v); end
        send_frame(0, 8'h1C, 1'b0, 1'b1);
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h10) begin bad++; $display("FAIL t4_stop got=%h want=10", v); end
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t4_stop_clr got=%h want=00", v); end
    endtask

    task automatic test_overflow();
        logic [7:0] v; logic [9:0] got, exp;
        for (int i = 1; i <= 9; i++) send_frame(0, 8'(i));
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h07) begin bad++; $display("FAIL t5_full got=%h want=07", v); end
        for (int i = 0; i < 8; i++) begin
            pop_entry(0, got);
            exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
            total++; if (got !== exp) begin bad++; $display("FAIL t5_pop%0d got=%h want=%h", i, got, exp); end
        end
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h04) begin bad++; $display("FAIL t5_ovf got=%h want=04", v); end
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t5_ovf_clr got=%h want=00", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v; logic [9:0] exp;
        send_frame(0, 8'h21); send_frame(0, 8'h22);
        rd(0, 8'h09, 1'b1, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL unmapped got=%h want=00", v); end
        rd(0, P3, 1'b1, 4, v);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if ({2'b00, v} !== exp) begin bad++; $display("FAIL hold_pop got=%h want=%h", v, exp); end
        rd(0, P3, 1'b1, 1, v);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if ({2'b00, v} !== exp) begin bad++; $display("FAIL hold_next got=%h want=%h", v, exp); end
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL hold_empty got=%h want=00", v); end
    endtask

    task automatic test_timeout_reset();
        logic [7:0] v; logic [9:0] got, exp;
        send_frame(0, 8'h00, 1'b0, 1'b0, 5);
        repeat (2100) @(negedge CLK);
        rd(0, B, 1'b1, 1, v);
        total++; if (v !== 8'h10) begin bad++; $display("FAIL t6_timeout got=%h want=10", v); end
        send_frame(0, 8'h16);
        pop_entry(0, got);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if (got !== exp) begin bad++; $display("FAIL t6_after_to got=%h want=%h", got, exp); end
        send_frame(0, 8'h2A);
        send_frame(0, 8'h4B, 1'b0, 1'b0, 4);
        @(negedge CLK); bus0.Port_ID = P1;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (bus0.Keyboard_Output !== 8'h00) begin bad++; $display("FAIL t6_rst_out got=%h want=00", bus0.Keyboard_Output); end
        total++; if (bus0.Interrupt !== 1'b0) begin bad++; $display("FAIL t6_rst_irq got=%b want=0", bus0.Interrupt); end
        do_reset();
        rd(0, B, 1'b0, 1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL t6_rst_status got=%h want=00", v); end
        send_frame(0, 8'h3C);
        pop_entry(0, got);
        exp = sb0.size() ? sb0.pop_front() : 10'h3FF;
        total++; if (got !== exp) begin bad++; $display("FAIL t6_after_rst got=%h want=%h", got, exp); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_key();
        test_prefix();
        test_no_break();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_timeout_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
